// File: rtl/cdb_broadcaster_pkg.sv
// Shared types and constants for the CDB broadcaster slice.
package cdb_broadcaster_pkg;

   // Physical register tag width and the reserved "no destination" tag
   localparam int PHYS_REG_W = 7;
   typedef logic [PHYS_REG_W-1:0] phys_reg_t;
   localparam phys_reg_t NO_TAG = 7'h7F;

   // Default number of completing sources (0=ALU, 1=MULT, 2=LD, 3=BR) and result width
   localparam int CDB_NUM_SRC = 4;
   localparam int CDB_DATA_W  = 64;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source completion FIFO: QDEPTH entries of {tag, value}, head visible
// combinationally so the arbiter can load it into the broadcast registers.
module cdb_src_fifo
   import cdb_broadcaster_pkg::*;
#(
   parameter int QDEPTH  = 2,
   parameter int ENTRY_W = PHYS_REG_W + CDB_DATA_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               push,
   input  logic               pop,
   input  logic [ENTRY_W-1:0] push_data,
   output logic               full,
   output logic               empty,
   output logic [ENTRY_W-1:0] head
);
   localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CNT_W = $clog2(QDEPTH) + 1;

   logic [ENTRY_W-1:0] mem_q [QDEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               do_push, do_pop;

   // Full/empty come straight from the count register, so a same-edge pop never frees a slot
   assign full  = (count_q == CNT_W'(QDEPTH));
   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];

   // Next-state for pointers and occupancy; push and pop may coincide
   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = (int'(wr_ptr_q) == QDEPTH-1) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = (int'(rd_ptr_q) == QDEPTH-1) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers; reset empties the queue
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are meaningless unless counted, so no reset needed
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB broadcaster: buffers FU completions per source, round-robin picks one
// per cycle and drives a registered single-cycle broadcast to RS/map/ROB.
module cdb_broadcaster
   import cdb_broadcaster_pkg::*;
#(
   parameter int NUM_SRC = CDB_NUM_SRC,
   parameter int QDEPTH  = 2,
   parameter int DATA_W  = CDB_DATA_W
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               enable,
   input  logic [NUM_SRC-1:0]                 fu_done,
   input  logic [NUM_SRC-1:0][PHYS_REG_W-1:0] fu_tag,
   input  logic [NUM_SRC-1:0][DATA_W-1:0]     fu_value,
   output logic [NUM_SRC-1:0]                 fu_stall,
   output logic                               CAM_en,
   output logic [PHYS_REG_W-1:0]              CDB_in,
   output logic [DATA_W-1:0]                  cdb_value,
   output logic [$clog2(NUM_SRC)-1:0]         cdb_src,
   output logic                               overflow
);
   localparam int SRC_W   = $clog2(NUM_SRC);
   localparam int ENTRY_W = PHYS_REG_W + DATA_W;

   logic [NUM_SRC-1:0] push_req, pop_req, full, empty;
   logic [ENTRY_W-1:0] head [NUM_SRC];

   logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [SRC_W-1:0]      win_idx;
   logic                  win_found;
   logic                  cam_en_q, cam_en_d;
   logic [PHYS_REG_W-1:0] cdb_tag_q, cdb_tag_d;
   logic [DATA_W-1:0]     cdb_value_q, cdb_value_d;
   logic [SRC_W-1:0]      cdb_src_q, cdb_src_d;
   logic                  overflow_q, overflow_d;

   // One FIFO per source; tagless completions (stores, no-dest ops) never enter
   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
         assign push_req[gi] = fu_done[gi] && (fu_tag[gi] != NO_TAG);

         cdb_src_fifo #(
            .QDEPTH  (QDEPTH),
            .ENTRY_W (ENTRY_W)
         ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (push_req[gi]),
            .pop       (pop_req[gi]),
            .push_data ({fu_tag[gi], fu_value[gi]}),
            .full      (full[gi]),
            .empty     (empty[gi]),
            .head      (head[gi])
         );
      end
   endgenerate

   // Round-robin search: first non-empty FIFO starting at rr_ptr, wrapping mod NUM_SRC
   always_comb begin
      int               cand;
      logic [SRC_W-1:0] cand_idx;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         cand = int'(rr_ptr_q) + k;
         if (cand >= NUM_SRC) begin
            cand = cand - NUM_SRC;
         end
         cand_idx = SRC_W'(cand);
         if (!win_found && !empty[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   // Pop the winner's head into the broadcast registers; idle cycles drive NO_TAG/0
   always_comb begin
      pop_req     = '0;
      rr_ptr_d    = rr_ptr_q;
      cam_en_d    = 1'b0;
      cdb_tag_d   = NO_TAG;
      cdb_value_d = '0;
      cdb_src_d   = cdb_src_q;
      overflow_d  = overflow_q | (|(push_req & full));
      if (enable && win_found) begin
         pop_req[win_idx]         = 1'b1;
         cam_en_d                 = 1'b1;
         {cdb_tag_d, cdb_value_d} = head[win_idx];
         cdb_src_d                = win_idx;
         rr_ptr_d = (int'(win_idx) == NUM_SRC-1) ? '0 : win_idx + SRC_W'(1);
      end
   end

   // Broadcast, pointer and sticky-overflow registers
   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr_q    <= '0;
         cam_en_q    <= 1'b0;
         cdb_tag_q   <= NO_TAG;
         cdb_value_q <= '0;
         cdb_src_q   <= '0;
         overflow_q  <= 1'b0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         cam_en_q    <= cam_en_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_value_q <= cdb_value_d;
         cdb_src_q   <= cdb_src_d;
         overflow_q  <= overflow_d;
      end
   end

   assign fu_stall  = full;
   assign CAM_en    = cam_en_q;
   assign CDB_in    = cdb_tag_q;
   assign cdb_value = cdb_value_q;
   assign cdb_src   = cdb_src_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Scoreboard bench for cdb_broadcaster: a queue-based reference model predicts
// each cycle's broadcast, stall and overflow; a negedge monitor compares.
module tb_cdb_broadcaster;
   localparam int NS = 4;
   localparam int QD = 2;
   localparam logic [6:0] NOTAG = 7'h7F;

   logic              clock = 1'b0;
   logic              reset;
   logic              enable;
   logic [NS-1:0]     fu_done;
   logic [NS-1:0][6:0]  fu_tag;
   logic [NS-1:0][63:0] fu_value;
   logic [NS-1:0]     fu_stall;
   logic              CAM_en;
   logic [6:0]        CDB_in;
   logic [63:0]       cdb_value;
   logic [1:0]        cdb_src;
   logic              overflow;

   int errors = 0;
   int checks = 0;

   cdb_broadcaster #(.NUM_SRC(NS), .QDEPTH(QD), .DATA_W(64)) dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .fu_done   (fu_done),
      .fu_tag    (fu_tag),
      .fu_value  (fu_value),
      .fu_stall  (fu_stall),
      .CAM_en    (CAM_en),
      .CDB_in    (CDB_in),
      .cdb_value (cdb_value),
      .cdb_src   (cdb_src),
      .overflow  (overflow)
   );

   always #5 clock = ~clock;

   // ---------------- reference model ----------------
   typedef struct {
      logic [6:0]  tag;
      logic [63:0] val;
      int          src;
   } ent_t;

   typedef struct {
      logic        cam;
      logic [6:0]  tag;
      logic [63:0] val;
      int          src;
      logic [3:0]  stall;
      logic        ovf;
   } exp_t;

   ent_t       pend[$];      // all buffered completions in arrival order
   exp_t       exp_q[$];     // scoreboard: expected output per cycle
   logic [6:0] seen[$];      // tags actually broadcast by the DUT
   int         rr = 0;
   logic       m_ovf = 1'b0;

   function automatic int count_src(int s);
      int n = 0;
      foreach (pend[j]) if (pend[j].src == s) n++;
      return n;
   endfunction

   // Model: at each edge, pop the round-robin winner (from pre-edge contents), then accept pushes
   always @(posedge clock) begin
      exp_t e;
      int   cnt[NS];
      int   s;
      bit   got;
      e.cam = 1'b0; e.tag = NOTAG; e.val = '0; e.src = 0; e.stall = '0;
      got = 1'b0;
      if (reset) begin
         pend.delete();
         rr    = 0;
         m_ovf = 1'b0;
      end else begin
         for (int i = 0; i < NS; i++) cnt[i] = count_src(i);
         if (enable) begin
            for (int k = 0; k < NS; k++) begin
               s = (rr + k) % NS;
               if (!got && cnt[s] > 0) begin
                  for (int j = 0; j < pend.size(); j++) begin
                     if (!got && pend[j].src == s) begin
                        e.cam = 1'b1; e.tag = pend[j].tag; e.val = pend[j].val; e.src = s;
                        pend.delete(j);
                        got = 1'b1;
                     end
                  end
                  rr = (s + 1) % NS;
               end
            end
         end
         for (int i = 0; i < NS; i++) begin
            if (fu_done[i] && fu_tag[i] != NOTAG) begin
               if (cnt[i] >= QD) m_ovf = 1'b1;
               else pend.push_back('{fu_tag[i], fu_value[i], i});
            end
         end
      end
      for (int i = 0; i < NS; i++) e.stall[i] = (count_src(i) == QD);
      e.ovf = m_ovf;
      exp_q.push_back(e);
   end

   // Monitor: one expectation per cycle, compared mid-cycle
   always @(negedge clock) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (CAM_en !== e.cam || CDB_in !== e.tag || cdb_value !== e.val ||
             (e.cam && int'(cdb_src) != e.src)) begin
            errors++;
            $display("FAIL bcast: got cam=%0b tag=%0d val=%h src=%0d, want cam=%0b tag=%0d val=%h src=%0d",
                     CAM_en, CDB_in, cdb_value, cdb_src, e.cam, e.tag, e.val, e.src);
         end else if (e.cam) begin
            $display("bcast src=%0d tag=%0d val=%h", cdb_src, CDB_in, cdb_value);
         end
         if (CAM_en === 1'b1) seen.push_back(CDB_in);
         checks++;
         if (fu_stall !== e.stall) begin
            errors++;
            $display("FAIL stall: got %b want %b", fu_stall, e.stall);
         end
         checks++;
         if (overflow !== e.ovf) begin
            errors++;
            $display("FAIL overflow: got %b want %b", overflow, e.ovf);
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic chk(string name, logic [63:0] act, logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   task automatic chk_seen(string name, logic [6:0] want[$]);
      checks++;
      if (seen.size() != want.size()) begin
         errors++;
         $display("FAIL %s: got %0d broadcasts want %0d", name, seen.size(), want.size());
      end else begin
         foreach (want[i]) begin
            if (seen[i] !== want[i]) begin
               errors++;
               $display("FAIL %s: broadcast %0d got tag %0d want %0d", name, i, seen[i], want[i]);
               break;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(int n);
      fu_done = '0;
      repeat (n) step();
   endtask

   task automatic do_reset();
      fu_done = '0;
      reset   = 1'b1;
      step();
      reset   = 1'b0;
   endtask

   task automatic push1(int s, logic [6:0] t, logic [63:0] v);
      fu_done     = '0;
      fu_done[s]  = 1'b1;
      fu_tag[s]   = t;
      fu_value[s] = v;
      step();
      fu_done = '0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [6:0] want[$];
      reset    = 1'b1;
      enable   = 1'b1;
      fu_done  = 4'b1111;
      fu_tag   = '0;
      fu_value = '0;
      for (int i = 0; i < NS; i++) begin
         fu_tag[i]   = 7'(i + 1);
         fu_value[i] = 64'(i + 100);
      end

      // 1: reset held two cycles while sources assert done
      step(); step();
      reset   = 1'b0;
      fu_done = '0;
      chk("reset_cam", 64'(CAM_en), 64'd0);
      chk("reset_tag", 64'(CDB_in), 64'h7F);
      chk("reset_stall", 64'(fu_stall), 64'd0);
      chk("reset_ovf", 64'(overflow), 64'd0);
      idle(3);
      chk_seen("reset_no_bcast", want);

      // 2: single completion, two-edge latency
      seen.delete();
      push1(1, 7'd3, 64'h2A);
      chk("single_not_early", 64'(CAM_en), 64'd0);
      idle(3);
      want = '{7'd3};
      chk_seen("single", want);

      // 3: round-robin across all sources, then two simultaneous from rr_ptr=0
      do_reset();
      seen.delete();
      fu_done = 4'b1111;
      for (int i = 0; i < NS; i++) begin
         fu_tag[i]   = 7'(10 + i);
         fu_value[i] = 64'(16'hA000 + i);
      end
      step();
      idle(6);
      fu_done = 4'b1001;
      fu_tag[0] = 7'd20; fu_value[0] = 64'h20;
      fu_tag[3] = 7'd23; fu_value[3] = 64'h23;
      step();
      idle(4);
      want = '{7'd10, 7'd11, 7'd12, 7'd13, 7'd20, 7'd23};
      chk_seen("round_robin", want);

      // 4: fill src2 with enable low, overflow on third push, then drain
      do_reset();
      seen.delete();
      enable = 1'b0;
      push1(2, 7'd5, 64'h5);
      push1(2, 7'd6, 64'h6);
      chk("stall_full", 64'(fu_stall[2]), 64'd1);
      push1(2, 7'd7, 64'h7);
      chk("overflow_set", 64'(overflow), 64'd1);
      enable = 1'b1;
      step();
      chk("stall_after_pop", 64'(fu_stall[2]), 64'd0);
      idle(4);
      want = '{7'd5, 7'd6};
      chk_seen("full_drain", want);
      chk("overflow_sticky", 64'(overflow), 64'd1);

      // 5: no-destination completion is ignored
      do_reset();
      seen.delete();
      push1(0, NOTAG, 64'hDEAD);
      idle(3);
      want = {};
      chk_seen("no_dest", want);
      chk("no_dest_ovf", 64'(overflow), 64'd0);
      chk("no_dest_stall", 64'(fu_stall), 64'd0);

      // 6: reset with entries queued discards them and restarts rr at 0
      enable  = 1'b0;
      fu_done = 4'b0111;
      fu_tag[0] = 7'd30; fu_tag[1] = 7'd31; fu_tag[2] = 7'd32;
      step();
      idle(1);
      do_reset();
      enable = 1'b1;
      seen.delete();
      idle(4);
      want = {};
      chk_seen("reset_discard", want);
      fu_done = 4'b0011;
      fu_tag[0] = 7'd41; fu_value[0] = 64'h41;
      fu_tag[1] = 7'd40; fu_value[1] = 64'h40;
      step();
      idle(4);
      want = '{7'd41, 7'd40};
      chk_seen("reset_rr_zero", want);

      // Random traffic, mostly honouring stall with occasional violations
      do_reset();
      for (int c = 0; c < 400; c++) begin
         enable = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NS; i++) begin
            fu_done[i]  = ($urandom_range(0, 1) == 1) &&
                          (count_src(i) < QD || $urandom_range(0, 31) == 0);
            fu_tag[i]   = 7'($urandom_range(0, 127));
            fu_value[i] = {$urandom, $urandom};
         end
         step();
      end
      enable = 1'b1;
      idle(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
